// File: rtl/fsm_serial_rx_param_if.sv
// Serial-line receiver bundle: line input in, frame result and error reporting out.
// The receiver takes the slave side; whoever drives the line and watches results takes master.
interface fsm_serial_rx_param_if #(
  parameter int DATA_BITS = 8,
  parameter int ERR_CNT_W = 8
);
  logic                 in;
  logic [DATA_BITS-1:0] out_data;
  logic                 done;
  logic                 parity_err;
  logic                 frame_err;
  logic [ERR_CNT_W-1:0] err_count;

  modport slave (
    input  in,
    output out_data, done, parity_err, frame_err, err_count
  );

  modport master (
    output in,
    input  out_data, done, parity_err, frame_err, err_count
  );
endinterface

// File: rtl/fsm_serial_rx_param.sv
// Parametrised serial-frame receiver (start, DATA_BITS LSB first, optional parity, 1-2 stops), one line bit per clk.
// Result pulses one cycle after the deciding bit is sampled; no backpressure, the line is consumed every cycle.
module fsm_serial_rx_param #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  fsm_serial_rx_param_if.slave bus
);

  if (DATA_BITS < 5 || DATA_BITS > 16 || PARITY < 0 || PARITY > 2 ||
      (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_param
    $error("fsm_serial_rx_param: illegal DATA_BITS/PARITY/STOP_BITS combination");
  end

  localparam int                   CNT_W      = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0]     LAST_BIT   = CNT_W'(DATA_BITS - 1);
  localparam logic                 LAST_STOP  = 1'(STOP_BITS - 1);
  localparam bit                   HAS_PARITY = (PARITY != 0);
  localparam logic                 ODD        = (PARITY == 2);
  localparam logic [ERR_CNT_W-1:0] CNT_MAX    = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_ERR
  } state_t;

  state_t                 state_q, state_nxt;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_nxt;
  logic                   stop_cnt_q, stop_cnt_nxt;
  logic [DATA_BITS-1:0]   shift_q, shift_nxt;
  logic                   par_bad_q, par_bad_nxt;
  logic [DATA_BITS-1:0]   out_data_q, out_data_nxt;
  logic                   done_q, done_nxt;
  logic                   parity_err_q, parity_err_nxt;
  logic                   frame_err_q, frame_err_nxt;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      stop_cnt_q   <= 1'b0;
      shift_q      <= '0;
      par_bad_q    <= 1'b0;
      out_data_q   <= '0;
      done_q       <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_nxt;
      bit_cnt_q    <= bit_cnt_nxt;
      stop_cnt_q   <= stop_cnt_nxt;
      shift_q      <= shift_nxt;
      par_bad_q    <= par_bad_nxt;
      out_data_q   <= out_data_nxt;
      done_q       <= done_nxt;
      parity_err_q <= parity_err_nxt;
      frame_err_q  <= frame_err_nxt;
      err_cnt_q    <= err_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state_q;
    bit_cnt_nxt    = bit_cnt_q;
    stop_cnt_nxt   = stop_cnt_q;
    shift_nxt      = shift_q;
    par_bad_nxt    = par_bad_q;
    out_data_nxt   = out_data_q;
    done_nxt       = 1'b0;
    parity_err_nxt = 1'b0;
    frame_err_nxt  = 1'b0;
    err_cnt_nxt    = err_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (!bus.in) begin
          state_nxt   = S_DATA;
          bit_cnt_nxt = '0;
          par_bad_nxt = 1'b0;
        end
      end
      S_DATA: begin
        shift_nxt[bit_cnt_q] = bus.in;
        bit_cnt_nxt          = bit_cnt_q + 1'b1;
        if (bit_cnt_q == LAST_BIT) begin
          bit_cnt_nxt  = '0;
          stop_cnt_nxt = 1'b0;
          state_nxt    = HAS_PARITY ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        // Even wants data^parity == 0, odd wants 1; ODD flips the sense.
        par_bad_nxt = (^shift_q) ^ bus.in ^ ODD;
        state_nxt   = S_STOP;
      end
      S_STOP: begin
        if (!bus.in) begin
          state_nxt     = S_ERR;
          frame_err_nxt = 1'b1;
        end else if (stop_cnt_q == LAST_STOP) begin
          state_nxt = S_IDLE;
          if (par_bad_q) begin
            parity_err_nxt = 1'b1;
          end else begin
            out_data_nxt = shift_q;
            done_nxt     = 1'b1;
          end
        end else begin
          stop_cnt_nxt = 1'b1;
        end
      end
      S_ERR: begin
        // A held-low line after a framing error must go high before a new start is accepted.
        if (bus.in) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    if ((parity_err_nxt || frame_err_nxt) && err_cnt_q != CNT_MAX)
      err_cnt_nxt = err_cnt_q + 1'b1;
  end

  assign bus.out_data   = out_data_q;
  assign bus.done       = done_q;
  assign bus.parity_err = parity_err_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.err_count  = err_cnt_q;

endmodule

// File: tb/tb_fsm_serial_rx_param.sv
// Bench for fsm_serial_rx_param: four parameter sets, frames built as transactions with expected events.
module tb_fsm_serial_rx_param;

  localparam int NDUT = 4;
  localparam int DB [NDUT] = '{8, 8, 8, 5};
  localparam int PR [NDUT] = '{0, 1, 0, 2};
  localparam int SB [NDUT] = '{1, 1, 2, 2};
  localparam int EW [NDUT] = '{8, 2, 8, 3};

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [NDUT-1:0]       line;
  logic [NDUT-1:0]       dn, pe, fe;
  logic [NDUT-1:0][15:0] od;
  logic [NDUT-1:0][7:0]  ec;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    fsm_serial_rx_param_if #(.DATA_BITS(DB[g]), .ERR_CNT_W(EW[g])) bus ();
    fsm_serial_rx_param #(
      .DATA_BITS(DB[g]), .PARITY(PR[g]), .STOP_BITS(SB[g]), .ERR_CNT_W(EW[g])
    ) u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
    );
    assign bus.in = line[g];
    assign od[g]  = 16'(bus.out_data);
    assign dn[g]  = bus.done;
    assign pe[g]  = bus.parity_err;
    assign fe[g]  = bus.frame_err;
    assign ec[g]  = 8'(bus.err_count);
  end

  typedef struct {
    int          cyc;
    int          typ;   // 1 done, 2 parity_err, 3 frame_err
    logic [15:0] dat;
  } ev_t;

  bit          stream [$];
  ev_t         exp_q [$];
  ev_t         obs_q [$];
  logic [15:0] last_good [NDUT];
  int          exp_cnt [NDUT];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic bump_err(input int k);
    if (exp_cnt[k] < (1 << EW[k]) - 1) exp_cnt[k]++;
  endtask

  // Appends one frame plus trailing line activity and records the outcome the rules predict.
  // stop_ok < SB[k] means stop bit number stop_ok is sent as 0, followed by hold extra zeros.
  task automatic add_frame(input int k, input logic [15:0] data, input bit par_bad,
                           input int stop_ok, input int hold, input int gap);
    bit  p;
    ev_t e;
    stream.push_back(1'b0);
    for (int i = 0; i < DB[k]; i++) stream.push_back(data[i]);
    if (PR[k] != 0) begin
      p = ^data;
      if (PR[k] == 2) p = ~p;
      if (par_bad) p = ~p;
      stream.push_back(p);
    end
    if (stop_ok >= SB[k]) begin
      for (int i = 0; i < SB[k]; i++) stream.push_back(1'b1);
      e.cyc = stream.size();
      if (par_bad && PR[k] != 0) begin
        e.typ = 2;
        bump_err(k);
      end else begin
        e.typ = 1;
        last_good[k] = data;
      end
      e.dat = last_good[k];
    end else begin
      for (int i = 0; i < stop_ok; i++) stream.push_back(1'b1);
      stream.push_back(1'b0);
      e.cyc = stream.size();
      e.typ = 3;
      e.dat = last_good[k];
      bump_err(k);
      for (int i = 0; i < hold; i++) stream.push_back(1'b0);
      stream.push_back(1'b1);
    end
    exp_q.push_back(e);
    for (int i = 0; i < gap; i++) stream.push_back(1'b1);
  endtask

  task automatic check_outputs(input int k, input string tag);
    chk($sformatf("%s_d%0d_pulses", tag, k), {29'd0, dn[k], pe[k], fe[k]}, 32'd0);
    chk($sformatf("%s_d%0d_out_data", tag, k), {16'd0, od[k]}, {16'd0, last_good[k]});
    chk($sformatf("%s_d%0d_err_count", tag, k), {24'd0, ec[k]}, exp_cnt[k]);
  endtask

  task automatic run_stream(input int k, input string tag);
    ev_t o;
    int  n;
    obs_q.delete();
    n = stream.size();
    for (int i = 0; i < n + 4; i++) begin
      @(posedge clk);
      #1 line[k] = (i < n) ? stream[i] : 1'b1;
      @(negedge clk);
      o.cyc = i;
      o.dat = od[k];
      if (dn[k]) begin o.typ = 1; obs_q.push_back(o); end
      if (pe[k]) begin o.typ = 2; obs_q.push_back(o); end
      if (fe[k]) begin o.typ = 3; obs_q.push_back(o); end
    end
    chk($sformatf("%s_d%0d_nevents", tag, k), obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      chk($sformatf("%s_d%0d_ev%0d_cycle", tag, k, i), obs_q[i].cyc, exp_q[i].cyc);
      chk($sformatf("%s_d%0d_ev%0d_type", tag, k, i), obs_q[i].typ, exp_q[i].typ);
      chk($sformatf("%s_d%0d_ev%0d_data", tag, k, i), {16'd0, obs_q[i].dat}, {16'd0, exp_q[i].dat});
    end
    check_outputs(k, tag);
    stream.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    for (int k = 0; k < NDUT; k++) begin
      last_good[k] = '0;
      exp_cnt[k]   = 0;
    end
  endtask

  initial begin
    int kind;
    logic [15:0] d;
    line = '1;
    for (int k = 0; k < NDUT; k++) begin
      last_good[k] = '0;
      exp_cnt[k]   = 0;
    end
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // T1: idle line after reset
    repeat (5) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) check_outputs(k, "t1_reset");

    // T2: single 8N1 frame
    add_frame(0, 16'h9A, 1'b0, 1, 0, 2);
    run_stream(0, "t2");

    // T3: even parity good then bad
    add_frame(1, 16'h03, 1'b0, 1, 0, 1);
    add_frame(1, 16'h03, 1'b1, 1, 0, 2);
    run_stream(1, "t3");

    // T4: two stop bits, second stop low, line held low, then recovery
    add_frame(2, 16'h55, 1'b0, 1, 4, 0);
    add_frame(2, 16'hA5, 1'b0, 2, 0, 2);
    run_stream(2, "t4");

    // T5: back-to-back frames, second start bit in the done cycle
    add_frame(0, 16'h11, 1'b0, 1, 0, 0);
    add_frame(0, 16'h22, 1'b0, 1, 0, 2);
    run_stream(0, "t5");

    // T6: reset after start plus four data bits
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 line[0] = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("t6_partial_quiet", {29'd0, dn[0], pe[0], fe[0]}, 32'd0);
    end
    @(posedge clk);
    #1 line[0] = 1'b1;
    do_reset();
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) check_outputs(k, "t6_reset");
    add_frame(0, 16'hC3, 1'b0, 1, 0, 2);
    run_stream(0, "t6");

    // Saturation of a 2-bit error counter
    for (int i = 0; i < 5; i++) add_frame(1, 16'($urandom_range(0, 255)), 1'b0, 0, 1, 1);
    run_stream(1, "sat");
    chk("sat_err_count_3", {24'd0, ec[1]}, 32'd3);

    // Randomised mix on every parameter set
    for (int k = 0; k < NDUT; k++) begin
      for (int f = 0; f < 12; f++) begin
        d    = 16'($urandom_range(0, (1 << DB[k]) - 1));
        kind = $urandom_range(0, 9);
        if (kind < 6)
          add_frame(k, d, 1'b0, SB[k], 0, $urandom_range(0, 3));
        else if (kind < 8)
          add_frame(k, d, (PR[k] != 0), SB[k], 0, $urandom_range(0, 3));
        else
          add_frame(k, d, 1'b0, $urandom_range(0, SB[k] - 1), $urandom_range(0, 3),
                    $urandom_range(0, 3));
      end
      run_stream(k, "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
